kp_bcd_key: RTL and testbench

KP_BCD_KEY -- requirements
Module: kp_bcd_key

---
 rtl/kp_pkg.sv | 39 +++
 rtl/kp_code_map.sv | 30 +++
 rtl/kp_bcd_key.sv | 148 ++++++++++++++
 tb/tb_kp_bcd_key.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kp_pkg.sv
// Shared types and constants for the keypad BCD key encoder.
// Holds the FSM state enum, special key indices and the digit-to-key table.
package kp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_PRESS,
        ST_SHIFT_GAP,
        ST_KEY_PRESS,
        ST_KEY_GAP
    } kp_state_t;

    localparam logic [3:0] KEY_SHIFT   = 4'd7;
    localparam logic [3:0] KEY_CLEAR   = 4'd0;
    localparam logic [3:0] KEY_NONE    = 4'd0;
    localparam logic [3:0] DIGIT_CLEAR = 4'hF;

    // Keypad matrix position of each decimal digit.
    localparam logic [3:0] KEY_DIGIT0 = 4'd1;
    localparam logic [3:0] KEY_DIGIT1 = 4'd12;
    localparam logic [3:0] KEY_DIGIT2 = 4'd13;
    localparam logic [3:0] KEY_DIGIT3 = 4'd14;
    localparam logic [3:0] KEY_DIGIT4 = 4'd8;
    localparam logic [3:0] KEY_DIGIT5 = 4'd9;
    localparam logic [3:0] KEY_DIGIT6 = 4'd10;
    localparam logic [3:0] KEY_DIGIT7 = 4'd4;
    localparam logic [3:0] KEY_DIGIT8 = 4'd5;
    localparam logic [3:0] KEY_DIGIT9 = 4'd6;

    function automatic logic isPressState(input kp_state_t state);
        return (state == ST_SHIFT_PRESS) || (state == ST_KEY_PRESS);
    endfunction

    // The phase counter counts down to zero, so a phase of N cycles loads N-1.
    function automatic logic [7:0] phaseReload(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/kp_code_map.sv
// Combinational digit-to-key translation for the keypad encoder.
// Digits 0xA-0xE have no key and are flagged as illegal.
module kp_code_map
    import kp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_key,
    output logic       o_legal
);

    always_comb begin
        o_key   = KEY_NONE;
        o_legal = 1'b1;
        case (i_digit)
            4'd0:        o_key = KEY_DIGIT0;
            4'd1:        o_key = KEY_DIGIT1;
            4'd2:        o_key = KEY_DIGIT2;
            4'd3:        o_key = KEY_DIGIT3;
            4'd4:        o_key = KEY_DIGIT4;
            4'd5:        o_key = KEY_DIGIT5;
            4'd6:        o_key = KEY_DIGIT6;
            4'd7:        o_key = KEY_DIGIT7;
            4'd8:        o_key = KEY_DIGIT8;
            4'd9:        o_key = KEY_DIGIT9;
            DIGIT_CLEAR: o_key = KEY_CLEAR;
            default:     o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/kp_bcd_key.sv
// Keypad encoder: turns accepted 5-bit codes into timed (d, valid) key presses,
// inserting a shift-key press whenever the requested shift differs from the decoder's mode.
module kp_bcd_key
    import kp_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [3:0] d,
    output logic       valid,
    output logic       err
);

    localparam logic [7:0] PRESS_RELOAD = phaseReload(PRESS_CYCLES);
    localparam logic [7:0] GAP_RELOAD   = phaseReload(GAP_CYCLES);

    kp_state_t  r_state;
    logic [7:0] r_count;
    logic       r_mode;
    logic [3:0] r_key;
    logic [3:0] r_d;
    logic       r_valid;
    logic       r_err;

    kp_state_t  w_nextState;
    logic [7:0] w_nextCount;
    logic       w_nextMode;
    logic [3:0] w_nextKey;
    logic [3:0] w_nextD;
    logic       w_nextValid;
    logic       w_nextErr;
    logic [3:0] w_mapKey;
    logic       w_legal;
    logic       w_accept;
    logic       w_phaseDone;

    kp_code_map u_codeMap (
        .i_digit (code_in[3:0]),
        .o_key   (w_mapKey),
        .o_legal (w_legal)
    );

    assign w_accept    = (r_state == ST_IDLE) && code_valid;
    assign w_phaseDone = (r_count == 8'd0);

    // Next-state logic; outputs are derived from the next state so they can be registered.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_nextMode  = r_mode;
        w_nextKey   = r_key;
        w_nextErr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_nextErr = 1'b1;
                    end else begin
                        w_nextKey   = w_mapKey;
                        w_nextCount = PRESS_RELOAD;
                        if (code_in[4] != r_mode) begin
                            w_nextState = ST_SHIFT_PRESS;
                        end else begin
                            w_nextState = ST_KEY_PRESS;
                        end
                    end
                end
            end
            ST_SHIFT_PRESS: begin
                if (w_phaseDone) begin
                    w_nextState = ST_SHIFT_GAP;
                    w_nextCount = GAP_RELOAD;
                    w_nextMode  = ~r_mode;
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
            ST_SHIFT_GAP: begin
                if (w_phaseDone) begin
                    w_nextState = ST_KEY_PRESS;
                    w_nextCount = PRESS_RELOAD;
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
            ST_KEY_PRESS: begin
                if (w_phaseDone) begin
                    w_nextState = ST_KEY_GAP;
                    w_nextCount = GAP_RELOAD;
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
            ST_KEY_GAP: begin
                if (w_phaseDone) begin
                    w_nextState = ST_IDLE;
                    w_nextCount = 8'd0;
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCount = 8'd0;
            end
        endcase

        w_nextValid = isPressState(w_nextState);
        if (w_nextState == ST_SHIFT_PRESS) begin
            w_nextD = KEY_SHIFT;
        end else if (w_nextState == ST_KEY_PRESS) begin
            w_nextD = w_nextKey;
        end else begin
            w_nextD = KEY_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 8'd0;
            r_mode  <= 1'b0;
            r_key   <= KEY_NONE;
            r_d     <= KEY_NONE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_mode  <= w_nextMode;
            r_key   <= w_nextKey;
            r_d     <= w_nextD;
            r_valid <= w_nextValid;
            r_err   <= w_nextErr;
        end
    end

    assign code_ready = (r_state == ST_IDLE);
    assign d          = r_d;
    assign valid      = r_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_kp_bcd_key.sv
// Bench for kp_bcd_key: directed code table, multi-cycle corner sequences,
// and random traffic checked every cycle against a queue-based press-schedule model.
module tb_kp_bcd_key;

    localparam int PRESS = 4;
    localparam int GAP   = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic [3:0] d;
    logic       valid;
    logic       err;

    int total = 0;
    int bad   = 0;

    kp_bcd_key #(.PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .d          (d),
        .valid      (valid),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted code becomes a list of per-cycle (d, valid) steps.
    typedef struct packed {
        logic [3:0] d;
        logic       v;
    } step_t;

    step_t      mQ[$];
    step_t      mStep;
    logic       mMode  = 1'b0;
    logic [3:0] mD     = 4'd0;
    logic       mV     = 1'b0;
    logic       mErr   = 1'b0;
    logic       mReady = 1'b1;
    logic [3:0] mDigit;
    int         keyTable [10] = '{1, 12, 13, 14, 8, 9, 10, 4, 5, 6};

    function automatic logic [3:0] keyFor(input logic [3:0] digit);
        if (digit == 4'hF) return 4'd0;
        return 4'(keyTable[digit]);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mQ.delete();
            mMode  = 1'b0;
            mD     = 4'd0;
            mV     = 1'b0;
            mErr   = 1'b0;
            mReady = 1'b1;
        end else begin
            mErr = 1'b0;
            if (mReady && code_valid) begin
                mDigit = code_in[3:0];
                if (mDigit > 4'd9 && mDigit != 4'hF) begin
                    mErr = 1'b1;
                end else begin
                    if (code_in[4] != mMode) begin
                        for (int i = 0; i < PRESS; i++) mQ.push_back('{d: 4'd7, v: 1'b1});
                        for (int i = 0; i < GAP; i++)   mQ.push_back('{d: 4'd0, v: 1'b0});
                        mMode = ~mMode;
                    end
                    for (int i = 0; i < PRESS; i++) mQ.push_back('{d: keyFor(mDigit), v: 1'b1});
                    for (int i = 0; i < GAP; i++)   mQ.push_back('{d: 4'd0, v: 1'b0});
                end
            end
            if (mQ.size() > 0) begin
                mStep  = mQ.pop_front();
                mD     = mStep.d;
                mV     = mStep.v;
                mReady = 1'b0;
            end else begin
                mD     = 4'd0;
                mV     = 1'b0;
                mReady = 1'b1;
            end
        end
        #1;
        check("model d", {4'd0, d}, {4'd0, mD});
        check("model valid", {7'd0, valid}, {7'd0, mV});
        check("model err", {7'd0, err}, {7'd0, mErr});
        check("model ready", {7'd0, code_ready}, {7'd0, mReady});
    end

    typedef struct packed {
        logic [4:0] code;
        logic       expErr;
        logic       expShift;
        logic [3:0] expKey;
    } vec_t;

    vec_t tbl [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a code, waits (bounded) for it to be taken, then scrambles code_in.
    task automatic applyStimulus(input logic [4:0] code);
        int n;
        @(negedge clk);
        code_in    = code;
        code_valid = 1'b1;
        n = 0;
        while (!code_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!code_ready) begin
            check("ready timeout", {7'd0, code_ready}, 8'd1);
        end
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_in    = 5'($urandom_range(0, 31));
    endtask

    task automatic checkOutput(input vec_t v);
        if (v.expErr) begin
            check("err pulse", {7'd0, err}, 8'd1);
            check("err no valid", {7'd0, valid}, 8'd0);
            check("err ready", {7'd0, code_ready}, 8'd1);
            step();
            check("err clear", {7'd0, err}, 8'd0);
            check("err still no valid", {7'd0, valid}, 8'd0);
        end else begin
            if (v.expShift) begin
                for (int i = 0; i < PRESS; i++) begin
                    check("shift press", {3'd0, valid, d}, {3'd0, 1'b1, 4'd7});
                    step();
                end
                for (int i = 0; i < GAP; i++) begin
                    check("shift gap", {2'd0, code_ready, valid, d}, 8'd0);
                    step();
                end
            end
            for (int i = 0; i < PRESS; i++) begin
                check("key press", {3'd0, valid, d}, {3'd0, 1'b1, v.expKey});
                check("key busy", {7'd0, code_ready}, 8'd0);
                step();
            end
            for (int i = 0; i < GAP; i++) begin
                check("key gap", {2'd0, code_ready, valid, d}, 8'd0);
                step();
            end
            check("ready after gap", {7'd0, code_ready}, 8'd1);
        end
    endtask

    initial begin
        tbl[0] = '{code: 5'h05, expErr: 1'b0, expShift: 1'b0, expKey: 4'd9};
        tbl[1] = '{code: 5'h12, expErr: 1'b0, expShift: 1'b1, expKey: 4'd13};
        tbl[2] = '{code: 5'h13, expErr: 1'b0, expShift: 1'b0, expKey: 4'd14};
        tbl[3] = '{code: 5'h0F, expErr: 1'b0, expShift: 1'b1, expKey: 4'd0};
        tbl[4] = '{code: 5'h0B, expErr: 1'b1, expShift: 1'b0, expKey: 4'd0};
        tbl[5] = '{code: 5'h1E, expErr: 1'b1, expShift: 1'b0, expKey: 4'd0};
        tbl[6] = '{code: 5'h07, expErr: 1'b0, expShift: 1'b0, expKey: 4'd4};
        tbl[7] = '{code: 5'h1A, expErr: 1'b1, expShift: 1'b0, expKey: 4'd0};
        tbl[8] = '{code: 5'h18, expErr: 1'b0, expShift: 1'b1, expKey: 4'd5};
        tbl[9] = '{code: 5'h00, expErr: 1'b0, expShift: 1'b1, expKey: 4'd1};

        rst_n      = 1'b0;
        code_in    = 5'd0;
        code_valid = 1'b0;
        #3;
        check("reset d", {4'd0, d}, 8'd0);
        check("reset valid", {7'd0, valid}, 8'd0);
        check("reset err", {7'd0, err}, 8'd0);
        check("reset ready", {7'd0, code_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed code table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].code);
            checkOutput(tbl[i]);
        end

        $display("[TB] back-to-back codes with valid held");
        @(negedge clk);
        code_in    = 5'h01;
        code_valid = 1'b1;
        step();
        code_in = 5'h09;
        for (int i = 0; i < PRESS; i++) begin
            check("b2b first press", {3'd0, valid, d}, {3'd0, 1'b1, 4'd12});
            step();
        end
        for (int i = 0; i < GAP; i++) begin
            check("b2b first gap", {3'd0, valid, d}, 8'd0);
            step();
        end
        check("b2b ready window", {7'd0, code_ready}, 8'd1);
        step();
        code_valid = 1'b0;
        check("b2b second press", {3'd0, valid, d}, {3'd0, 1'b1, 4'd6});
        check("b2b second busy", {7'd0, code_ready}, 8'd0);
        for (int i = 0; i < PRESS + GAP; i++) step();
        check("b2b done", {7'd0, code_ready}, 8'd1);

        $display("[TB] reset during key press");
        applyStimulus(5'h12);
        for (int i = 0; i < PRESS + GAP + 1; i++) step();
        check("pre-reset press", {3'd0, valid, d}, {3'd0, 1'b1, 4'd13});
        #2;
        rst_n = 1'b0;
        #1;
        check("async drop valid", {7'd0, valid}, 8'd0);
        check("async drop d", {4'd0, d}, 8'd0);
        check("async ready", {7'd0, code_ready}, 8'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * (PRESS + GAP); i++) begin
            step();
            check("no resumed press", {7'd0, valid}, 8'd0);
        end
        applyStimulus(5'h05);
        checkOutput('{code: 5'h05, expErr: 1'b0, expShift: 1'b0, expKey: 4'd9});

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            code_valid = ($urandom_range(0, 3) != 0);
            code_in    = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        code_valid = 1'b0;
        for (int n = 0; n < 3 * (PRESS + GAP); n++) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
